// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: one write port, two registered read ports
// with valid flags, and the clear request / busy pair.
interface reg_file_param_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic [WIDTH-1:0]  IN;
    logic [ADDR_W-1:0] INADDRESS;
    logic              WRITE;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [WIDTH-1:0]  OUT1;
    logic [WIDTH-1:0]  OUT2;
    logic              OUT1VALID;
    logic              OUT2VALID;
    logic              CLEAR;
    logic              BUSY;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        input  OUT1, OUT2, OUT1VALID, OUT2VALID, BUSY
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        output OUT1, OUT2, OUT1VALID, OUT2VALID, BUSY
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file: two registered read ports with per-register
// valid flags, optional write forwarding, optional zero register, sequential clear.
//
// state | meaning
// IDLE  | normal operation, writes accepted
// CLR   | zeroing one register per cycle at cnt; writes and CLEAR ignored
module reg_file_param #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic              CLOCK,
    input logic              RESET,
    reg_file_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLR} state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] cnt;
    logic              busy;
    logic [WIDTH-1:0]  out1;
    logic [WIDTH-1:0]  out2;
    logic              out1_v;
    logic              out2_v;

    logic zero_wr, wr_acc, fwd1, fwd2, zero1, zero2;

    // A discarded write to the zero register must neither store nor forward.
    assign zero_wr = (ZERO_REG != 0) && (bus.INADDRESS == '0);
    assign wr_acc  = bus.WRITE && !busy && !zero_wr;
    assign fwd1    = (BYPASS != 0) && wr_acc && (bus.INADDRESS == bus.OUT1ADDRESS);
    assign fwd2    = (BYPASS != 0) && wr_acc && (bus.INADDRESS == bus.OUT2ADDRESS);
    assign zero1   = (ZERO_REG != 0) && (bus.OUT1ADDRESS == '0);
    assign zero2   = (ZERO_REG != 0) && (bus.OUT2ADDRESS == '0);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            valid  <= '0;
            out1   <= '0;
            out2   <= '0;
            out1_v <= 1'b0;
            out2_v <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CLEAR) begin
                        state <= CLR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLR: begin
                    mem[cnt]   <= '0;
                    valid[cnt] <= 1'b0;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // wr_acc is never true in CLR, so this cannot collide with the clear.
            if (wr_acc) begin
                mem[bus.INADDRESS]   <= bus.IN;
                valid[bus.INADDRESS] <= 1'b1;
            end

            if (zero1) begin
                out1   <= '0;
                out1_v <= 1'b1;
            end else if (fwd1) begin
                out1   <= bus.IN;
                out1_v <= 1'b1;
            end else begin
                out1   <= mem[bus.OUT1ADDRESS];
                out1_v <= valid[bus.OUT1ADDRESS];
            end

            if (zero2) begin
                out2   <= '0;
                out2_v <= 1'b1;
            end else if (fwd2) begin
                out2   <= bus.IN;
                out2_v <= 1'b1;
            end else begin
                out2   <= mem[bus.OUT2ADDRESS];
                out2_v <= valid[bus.OUT2ADDRESS];
            end
        end
    end

    assign bus.OUT1      = out1;
    assign bus.OUT2      = out2;
    assign bus.OUT1VALID = out1_v;
    assign bus.OUT2VALID = out2_v;
    assign bus.BUSY      = busy;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: three variants (forwarding, no forwarding,
// zero register) driven with identical stimulus and checked against hand values.
module tb_reg_file_param;
    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] in_d  = '0;
    logic [2:0] waddr = '0;
    logic [2:0] a1    = '0;
    logic [2:0] a2    = '0;
    logic       wr    = 1'b0;
    logic       clr   = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLOCK = ~CLOCK;

    reg_file_param_if #(.WIDTH(8), .ADDR_W(3)) bus_a ();
    reg_file_param_if #(.WIDTH(8), .ADDR_W(3)) bus_n ();
    reg_file_param_if #(.WIDTH(8), .ADDR_W(3)) bus_z ();

    assign bus_a.IN = in_d;  assign bus_a.INADDRESS = waddr;  assign bus_a.WRITE = wr;
    assign bus_a.OUT1ADDRESS = a1;  assign bus_a.OUT2ADDRESS = a2;  assign bus_a.CLEAR = clr;
    assign bus_n.IN = in_d;  assign bus_n.INADDRESS = waddr;  assign bus_n.WRITE = wr;
    assign bus_n.OUT1ADDRESS = a1;  assign bus_n.OUT2ADDRESS = a2;  assign bus_n.CLEAR = clr;
    assign bus_z.IN = in_d;  assign bus_z.INADDRESS = waddr;  assign bus_z.WRITE = wr;
    assign bus_z.OUT1ADDRESS = a1;  assign bus_z.OUT2ADDRESS = a2;  assign bus_z.CLEAR = clr;

    reg_file_param #(.WIDTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus_a));
    reg_file_param #(.WIDTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus_n));
    reg_file_param #(.WIDTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus_z));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic [7:0] act_o, input logic act_v,
                            input logic [7:0] exp_o, input logic exp_v);
        chk({tag, ".data"}, {24'h0, act_o}, {24'h0, exp_o});
        chk({tag, ".valid"}, {31'h0, act_v}, {31'h0, exp_v});
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset held with write and clear requested: must have no effect
        wr = 1'b1; waddr = 3'd6; in_d = 8'h66; clr = 1'b1;
        #3;
        chk("rst_busy", {31'h0, bus_a.BUSY}, 32'h0);
        chk_port("rst_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h00, 1'b0);
        chk_port("rst_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'h00, 1'b0);
        tick; tick;
        wr = 1'b0; clr = 1'b0; RESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i);
            tick;
            chk_port("init_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h00, 1'b0);
            chk_port("init_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'h00, 1'b0);
            chk_port("init_z1", bus_z.OUT1, bus_z.OUT1VALID, 8'h00, i == 0);
            chk("init_busy", {31'h0, bus_a.BUSY}, 32'h0);
        end

        // basic write then read, unwritten neighbour
        wr = 1'b1; waddr = 3'd3; in_d = 8'h5A; a1 = 3'd0; a2 = 3'd0;
        tick;
        wr = 1'b0; a1 = 3'd3; a2 = 3'd4;
        tick;
        chk_port("wr3_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h5A, 1'b1);
        chk_port("wr3_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'h00, 1'b0);
        chk_port("wr3_n1", bus_n.OUT1, bus_n.OUT1VALID, 8'h5A, 1'b1);

        // same-edge forwarding vs pre-write value
        wr = 1'b1; waddr = 3'd2; in_d = 8'h21;
        tick;
        in_d = 8'hC3; a1 = 3'd2; a2 = 3'd2;
        tick;
        chk_port("byp_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'hC3, 1'b1);
        chk_port("byp_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'hC3, 1'b1);
        chk_port("byp_n1", bus_n.OUT1, bus_n.OUT1VALID, 8'h21, 1'b1);
        chk_port("byp_n2", bus_n.OUT2, bus_n.OUT2VALID, 8'h21, 1'b1);
        waddr = 3'd5; in_d = 8'h77;
        tick;
        chk_port("nofwd_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'hC3, 1'b1);
        chk_port("late_n1", bus_n.OUT1, bus_n.OUT1VALID, 8'hC3, 1'b1);
        wr = 1'b0;

        // fill, then sequential clear with ignored write and ignored re-CLEAR
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; waddr = 3'(i); in_d = 8'(16 + i);
            tick;
        end
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(i);
            tick;
            chk_port("fill_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'(16 + i), 1'b1);
            chk_port("fill_z2", bus_z.OUT2, bus_z.OUT2VALID, (i == 0) ? 8'h00 : 8'(16 + i), 1'b1);
        end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_busy0", {31'h0, bus_a.BUSY}, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            a1 = 3'(k - 1); a2 = 3'(k - 2);
            if (k == 2) begin
                wr = 1'b1; waddr = 3'd7; in_d = 8'hFF; clr = 1'b1;
            end
            tick;
            wr = 1'b0; clr = 1'b0;
            chk("clr_busy", {31'h0, bus_a.BUSY}, {31'h0, k < 8});
            chk_port("clr_pre_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'(16 + k - 1), 1'b1);
            chk_port("clr_a2", bus_a.OUT2, bus_a.OUT2VALID, (k == 1) ? 8'h17 : 8'h00, k == 1);
            chk_port("clr_z1", bus_z.OUT1, bus_z.OUT1VALID, (k == 1) ? 8'h00 : 8'(16 + k - 1), 1'b1);
            chk("clr_zbusy", {31'h0, bus_z.BUSY}, {31'h0, k < 8});
        end
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i);
            tick;
            chk_port("post_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h00, 1'b0);
            chk_port("post_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'h00, 1'b0);
            chk_port("post_z1", bus_z.OUT1, bus_z.OUT1VALID, 8'h00, i == 0);
        end

        // async reset in the middle of a clear
        wr = 1'b1; waddr = 3'd1; in_d = 8'h33;
        tick;
        waddr = 3'd4; in_d = 8'h44;
        tick;
        wr = 1'b0; a1 = 3'd4; a2 = 3'd4;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        tick; tick; tick;
        chk("mid_busy", {31'h0, bus_a.BUSY}, 32'h1);
        chk_port("mid_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h44, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_busy", {31'h0, bus_a.BUSY}, 32'h0);
        chk_port("arst_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h00, 1'b0);
        chk_port("arst_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'h00, 1'b0);
        #1;
        RESET = 1'b0;
        tick;
        chk_port("arst_rd4", bus_a.OUT1, bus_a.OUT1VALID, 8'h00, 1'b0);
        chk("arst_busy2", {31'h0, bus_a.BUSY}, 32'h0);
        wr = 1'b1; waddr = 3'd1; in_d = 8'h11; a1 = 3'd1; a2 = 3'd1;
        tick;
        wr = 1'b0;
        chk_port("re_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h11, 1'b1);
        chk_port("re_n1", bus_n.OUT1, bus_n.OUT1VALID, 8'h00, 1'b0);
        tick;
        chk_port("re_n2", bus_n.OUT2, bus_n.OUT2VALID, 8'h11, 1'b1);

        // zero register: discarded write, no forwarding
        wr = 1'b1; waddr = 3'd0; in_d = 8'hAA; a1 = 3'd0; a2 = 3'd0;
        tick;
        wr = 1'b0;
        chk_port("z_fwd1", bus_z.OUT1, bus_z.OUT1VALID, 8'h00, 1'b1);
        chk_port("z_fwd2", bus_z.OUT2, bus_z.OUT2VALID, 8'h00, 1'b1);
        chk_port("z_ref_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'hAA, 1'b1);
        tick;
        chk_port("z_rd1", bus_z.OUT1, bus_z.OUT1VALID, 8'h00, 1'b1);
        chk_port("z_ref_a2", bus_a.OUT2, bus_a.OUT2VALID, 8'hAA, 1'b1);

        // CLEAR and WRITE together in IDLE: write lands, then is erased
        clr = 1'b1; wr = 1'b1; waddr = 3'd5; in_d = 8'h55; a1 = 3'd5;
        tick;
        clr = 1'b0; wr = 1'b0;
        chk_port("cw_a1", bus_a.OUT1, bus_a.OUT1VALID, 8'h55, 1'b1);
        chk("cw_busy", {31'h0, bus_a.BUSY}, 32'h1);
        repeat (7) tick;
        chk("cw_busy7", {31'h0, bus_a.BUSY}, 32'h1);
        tick;
        chk("cw_busy8", {31'h0, bus_a.BUSY}, 32'h0);
        tick;
        chk_port("cw_rd5", bus_a.OUT1, bus_a.OUT1VALID, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
- REQ-001 SHALL provide parameter WIDTH, default 8, data width of each register and port.
- REQ-002 SHALL provide parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
- REQ-003 SHALL provide parameter BYPASS, default 1; 1 = same-edge write-to-read forwarding, 0 = read returns pre-write value.
- REQ-004 SHALL provide parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero, writes to it discarded.
- REQ-005 CLOCK  input  1  single clock; all state changes on rising edge.
- REQ-006 RESET  input  1  asynchronous, active-high reset.
- REQ-007 IN  input  WIDTH  write data.
- REQ-008 INADDRESS  input  ADDR_W  write address.
- REQ-009 WRITE  input  1  write enable, sampled on rising CLOCK.
- REQ-010 OUT1ADDRESS, OUT2ADDRESS  input  ADDR_W  read addresses for ports 1 and 2.
- REQ-011 OUT1, OUT2  output  WIDTH  registered read data.
- REQ-012 OUT1VALID, OUT2VALID  output  1  registered "register written since last clear/reset" flag for the addressed register.
- REQ-013 CLEAR  input  1  single-cycle request to start a sequential clear of all registers.
- REQ-014 BUSY  output  1  high while the clear sequence runs.

Function
- REQ-015 Storage SHALL be DEPTH x WIDTH registers plus DEPTH valid bits.
- REQ-016 Write SHALL occur at rising CLOCK when WRITE=1 and BUSY=0: reg[INADDRESS] <= IN, valid[INADDRESS] <= 1.
- REQ-017 WRITE=1 while BUSY=1 SHALL be ignored (no register or valid bit change).
- REQ-018 Reads SHALL have 1-cycle latency: at each rising edge OUTn <= reg[OUTnADDRESS], OUTnVALID <= valid[OUTnADDRESS], addresses sampled at that edge.
- REQ-019 BYPASS=1: if an accepted write targets OUTnADDRESS at the same edge, OUTn SHALL load IN and OUTnVALID SHALL load 1.
- REQ-020 BYPASS=0: same case SHALL load the pre-write value and valid bit; new value visible one edge later.
- REQ-021 Both read ports SHALL operate independently; equal addresses SHALL yield identical outputs.
- REQ-022 ZERO_REG=1: reads of address 0 SHALL return 0 with valid=1; writes to address 0 SHALL be discarded and SHALL NOT forward.
- REQ-023 Clear FSM states: IDLE, CLR; reset state IDLE.
- REQ-024 IDLE->CLR when CLEAR=1 at a rising edge; counter loads 0; BUSY=1 from that edge.
- REQ-025 In CLR, each edge SHALL zero reg[cnt] and valid[cnt] then increment cnt; CLR->IDLE at the edge clearing address DEPTH-1; BUSY high exactly DEPTH cycles.
- REQ-026 CLEAR while BUSY=1 SHALL be ignored (no restart).
- REQ-027 CLEAR and WRITE at the same edge in IDLE: write SHALL be accepted at that edge and later erased by the sequence.
- REQ-028 Reads during CLR SHALL continue and return current contents (cleared or not yet cleared); a read of address cnt at the edge clearing it SHALL return the pre-clear value.

Reset
- REQ-029 RESET=1 SHALL immediately, without a clock, zero all registers, valid bits, OUT1, OUT2, OUT1VALID, OUT2VALID, BUSY, counter, and force IDLE.
- REQ-030 RESET asserted mid-clear SHALL abort the sequence; after release the block SHALL be IDLE, BUSY=0, contents all zero.
- REQ-031 While RESET=1, WRITE and CLEAR SHALL have no effect.

Verification
- REQ-032 Reset then read all addresses -> OUT1=OUT2=0x00, OUTnVALID=0 for every address.
- REQ-033 Write 0x5A to addr 3, next cycle OUT1ADDRESS=3 -> OUT1=0x5A, OUT1VALID=1 one edge later; OUT2 on unwritten addr 4 -> 0x00, valid 0.
- REQ-034 Same-edge write 0xC3 to addr 2 with OUT1ADDRESS=OUT2ADDRESS=2 -> BYPASS=1: both 0xC3 after that edge; BYPASS=0: old value, 0xC3 one edge later.
- REQ-035 Fill all 8 registers, pulse CLEAR, attempt write 0xFF to addr 7 at cycle 2 of clear -> BUSY high exactly 8 cycles, write ignored, all reads 0x00 valid 0 afterwards.
- REQ-036 Assert RESET asynchronously at cycle 4 of a clear -> BUSY falls without clock edge, all outputs 0, subsequent write/read of addr 1 with 0x11 works normally.
- REQ-037 ZERO_REG=1: write 0xAA to addr 0 -> reads of addr 0 return 0x00 with valid=1, including same-edge forwarding case.
